// File: rtl/x4_readout_pkg.sv
// Shared definitions for the 4-channel capture-buffer readout: FSM state
// encoding, default frame header and the frame-length helper.
package x4_readout_pkg;

    localparam int NUM_CH = 4;

    localparam logic [15:0] HEADER_DEFAULT = 16'hA5A5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_CNT  = 3'd2,
        ST_LOAD = 3'd3,
        ST_SEND = 3'd4,
        ST_SUM  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Stream words per frame: header, count, four words per sample set, checksum.
    function automatic int frame_words(input int depth);
        return 2 + NUM_CH * depth + 1;
    endfunction

endpackage

// File: rtl/x4_readout_ser.sv
// 4:1 serializer for one captured sample set: selects the current channel
// word from the holding registers, steps the channel index on each accepted
// word and accumulates the running frame checksum.
module x4_readout_ser
    import x4_readout_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 accept,
    input  logic [NUM_CH*DW-1:0] hold_flat,
    output logic [DW-1:0]        word,
    output logic                 last_word,
    output logic [DW-1:0]        checksum
);

    logic [1:0]    index_reg;
    logic [DW-1:0] checksum_reg;

    // Channel index restarts at A for every new sample set; checksum restarts per frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            index_reg    <= '0;
            checksum_reg <= '0;
        end else begin
            if (clear) begin
                checksum_reg <= '0;
            end else if (accept) begin
                checksum_reg <= checksum_reg + word;
            end
            if (clear || load) begin
                index_reg <= '0;
            end else if (accept) begin
                index_reg <= index_reg + 2'd1;
            end
        end
    end

    assign word      = hold_flat[index_reg*DW +: DW];
    assign last_word = (index_reg == 2'(NUM_CH - 1));
    assign checksum  = checksum_reg;

endmodule

// File: rtl/x4_channel_readout.sv
// Read-side sequencer for the 4-channel circular capture buffer. On START it
// walks every sample set once (one RENBL per set) and streams a framed word
// sequence: header, set count, A/B/C/D per set, then a 16-bit checksum.
module x4_channel_readout
    import x4_readout_pkg::*;
#(
    parameter int            DEPTH  = 512,
    parameter int            DW     = 16,
    parameter logic [DW-1:0] HEADER = DW'(HEADER_DEFAULT)
) (
    input  logic          RDCLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic          WR_ACTIVE,
    input  logic [DW-1:0] DOUTA,
    input  logic [DW-1:0] DOUTB,
    input  logic [DW-1:0] DOUTC,
    input  logic [DW-1:0] DOUTD,
    output logic          RENBL,
    output logic [DW-1:0] TDATA,
    output logic          TVALID,
    input  logic          TREADY,
    output logic          TLAST,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    localparam int            CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEPTH);
    localparam logic [DW-1:0] DEPTH_WORD = DW'(DEPTH);

    state_t                 state_reg, state_next;
    logic [CW-1:0]          count_reg, count_next;
    logic                   err_reg;
    logic [DW-1:0]          dout_bus [NUM_CH];
    logic [DW-1:0]          hold_reg [NUM_CH];
    logic [NUM_CH*DW-1:0]   hold_flat;
    logic                   start_ok;
    logic                   load_strobe;
    logic                   accept_strobe;
    logic [DW-1:0]          ser_word;
    logic                   ser_last;
    logic [DW-1:0]          ser_checksum;

    assign dout_bus[0] = DOUTA;
    assign dout_bus[1] = DOUTB;
    assign dout_bus[2] = DOUTC;
    assign dout_bus[3] = DOUTD;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_flat
            assign hold_flat[gi*DW +: DW] = hold_reg[gi];
        end
    endgenerate

    // A START that arrives while writing is still enabled never opens a frame.
    assign start_ok      = (state_reg == ST_IDLE) && START && !WR_ACTIVE;
    assign load_strobe   = (state_reg == ST_LOAD);
    assign accept_strobe = (state_reg == ST_SEND) && TREADY;

    // State, sample-set counter and sticky write-interlock error.
    always_ff @(posedge RDCLK) begin
        if (!RSTN) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (start_ok) begin
                err_reg <= 1'b0;
            end else if (BUSY && WR_ACTIVE) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Holding registers sample the buffer's async data on the same edge it advances.
    always_ff @(posedge RDCLK) begin
        if (!RSTN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hold_reg[i] <= '0;
            end
        end else if (load_strobe) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hold_reg[i] <= dout_bus[i];
            end
        end
    end

    // Next-state and stream outputs; every word-bearing state holds until accepted.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        RENBL      = 1'b0;
        TDATA      = '0;
        TVALID     = 1'b0;
        TLAST      = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_HDR;
                    count_next = '0;
                end
            end
            ST_HDR: begin
                BUSY   = 1'b1;
                TVALID = 1'b1;
                TDATA  = HEADER;
                if (TREADY) state_next = ST_CNT;
            end
            ST_CNT: begin
                BUSY   = 1'b1;
                TVALID = 1'b1;
                TDATA  = DEPTH_WORD;
                if (TREADY) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                BUSY       = 1'b1;
                RENBL      = 1'b1;
                count_next = count_reg + CW'(1);
                state_next = ST_SEND;
            end
            ST_SEND: begin
                BUSY   = 1'b1;
                TVALID = 1'b1;
                TDATA  = ser_word;
                if (TREADY && ser_last) begin
                    state_next = (count_reg == COUNT_LAST) ? ST_SUM : ST_LOAD;
                end
            end
            ST_SUM: begin
                BUSY   = 1'b1;
                TVALID = 1'b1;
                TLAST  = 1'b1;
                TDATA  = ser_checksum;
                if (TREADY) state_next = ST_DONE;
            end
            ST_DONE: begin
                DONE       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ERR = err_reg;

    x4_readout_ser #(
        .DW (DW)
    ) u_ser (
        .clk       (RDCLK),
        .rstn      (RSTN),
        .clear     (start_ok),
        .load      (load_strobe),
        .accept    (accept_strobe),
        .hold_flat (hold_flat),
        .word      (ser_word),
        .last_word (ser_last),
        .checksum  (ser_checksum)
    );

endmodule

// File: tb/tb_x4_channel_readout.sv
// Bench for x4_channel_readout: a 512-set buffer model feeding the default
// build and a 4-set buffer model feeding a DEPTH=4 build. Expected frames are
// rebuilt from the buffer contents starting at the address seen at START.
module tb_x4_channel_readout;

    localparam int D0 = 512;
    localparam int D1 = 4;

    typedef logic [15:0] wq_t[$];
    typedef bit          bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Main DUT (DEPTH=512)
    logic        RSTN, START, WR_ACTIVE, TREADY;
    logic [15:0] DOUTA, DOUTB, DOUTC, DOUTD;
    logic        RENBL, TVALID, TLAST, BUSY, DONE, ERR;
    logic [15:0] TDATA;

    // Small DUT (DEPTH=4)
    logic        START4, TREADY4, WR4;
    logic [15:0] DOUTA4, DOUTB4, DOUTC4, DOUTD4;
    logic        RENBL4, TVALID4, TLAST4, BUSY4, DONE4, ERR4;
    logic [15:0] TDATA4;

    function automatic logic [15:0] bufword(input int ch, input int addr);
        return {ch[1:0], addr[8:0], 5'b0};
    endfunction

    // Buffer models: async read at current address, advance on RENBL.
    int baddr = 0, baddr4 = 0, ren_cnt = 0, ren4 = 0, dbl_cnt = 0;
    logic prev_ren = 1'b0;
    assign DOUTA  = bufword(0, baddr);
    assign DOUTB  = bufword(1, baddr);
    assign DOUTC  = bufword(2, baddr);
    assign DOUTD  = bufword(3, baddr);
    assign DOUTA4 = bufword(0, baddr4);
    assign DOUTB4 = bufword(1, baddr4);
    assign DOUTC4 = bufword(2, baddr4);
    assign DOUTD4 = bufword(3, baddr4);

    always @(posedge clk) begin
        prev_ren <= RENBL;
        if (RENBL) begin
            baddr   <= (baddr + 1) % D0;
            ren_cnt <= ren_cnt + 1;
            if (prev_ren) dbl_cnt <= dbl_cnt + 1;
        end
        if (RENBL4) begin
            baddr4 <= (baddr4 + 1) % D1;
            ren4   <= ren4 + 1;
        end
    end

    // Stream capture and handshake-rule monitors, sampled mid-cycle.
    wq_t q_d, q4_d;
    bq_t q_l, q4_l;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b0;
    logic [15:0] pd = '0;
    int stall_cnt = 0, stall_viol = 0, overlap = 0;

    always @(negedge clk) begin
        if (RSTN && TVALID && TREADY) begin
            q_d.push_back(TDATA);
            q_l.push_back(TLAST);
        end
        if (RSTN && TVALID4 && TREADY4) begin
            q4_d.push_back(TDATA4);
            q4_l.push_back(TLAST4);
        end
        if (prst && RSTN && pv && !pr) begin
            stall_cnt <= stall_cnt + 1;
            if (!(TVALID === 1'b1 && TDATA === pd && TLAST === pl)) stall_viol <= stall_viol + 1;
        end
        if (RENBL && TVALID) overlap <= overlap + 1;
        pv   <= TVALID;
        pr   <= TREADY;
        pd   <= TDATA;
        pl   <= TLAST;
        prst <= RSTN;
    end

    x4_channel_readout #(.DEPTH(D0), .DW(16)) dut (
        .RDCLK(clk), .RSTN(RSTN), .START(START), .WR_ACTIVE(WR_ACTIVE),
        .DOUTA(DOUTA), .DOUTB(DOUTB), .DOUTC(DOUTC), .DOUTD(DOUTD),
        .RENBL(RENBL), .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY),
        .TLAST(TLAST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    x4_channel_readout #(.DEPTH(D1), .DW(16)) dut4 (
        .RDCLK(clk), .RSTN(RSTN), .START(START4), .WR_ACTIVE(WR4),
        .DOUTA(DOUTA4), .DOUTB(DOUTB4), .DOUTC(DOUTC4), .DOUTD(DOUTD4),
        .RENBL(RENBL4), .TDATA(TDATA4), .TVALID(TVALID4), .TREADY(TREADY4),
        .TLAST(TLAST4), .BUSY(BUSY4), .DONE(DONE4), .ERR(ERR4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
        $display("[TB] check %-24s observed %0h expected %0h", tag, obs, exp);
    endtask

    int ready_pct = 100;
    int f0, ren0, a0, s_cyc, d_cyc;

    task automatic tick();
        TREADY = ($urandom_range(99) < ready_pct);
        @(posedge clk);
        #1;
    endtask

    task automatic start_main();
        f0    = q_d.size();
        ren0  = ren_cnt;
        a0    = baddr;
        s_cyc = cyc;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < maxc; n++) begin
            if (DONE) begin
                ok    = 1'b1;
                d_cyc = cyc;
                break;
            end
            tick();
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    // Rebuild the frame from buffer contents and compare to what was accepted.
    task automatic check_frame(input string tag, input int depth, input int sa,
                               input int first, input wq_t qd, input bq_t ql);
        logic [15:0] e[$];
        logic [15:0] sum, w;
        int n, got, nmis, fidx;
        sum = '0;
        e.push_back(16'hA5A5);
        e.push_back(16'(depth));
        for (int i = 0; i < depth; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                w = bufword(ch, (sa + i) % depth);
                e.push_back(w);
                sum = sum + w;
            end
        end
        e.push_back(sum);
        n    = e.size();
        got  = qd.size() - first;
        nmis = 0;
        fidx = -1;
        chk({tag, "_len"}, 32'(got), 32'(n));
        for (int k = 0; k < n && k < got; k++) begin
            if (qd[first+k] !== e[k] || ql[first+k] !== (k == n - 1)) begin
                if (fidx < 0) fidx = k;
                nmis++;
            end
        end
        if (fidx >= 0)
            $display("[TB] %s first differing word %0d: got %h last=%0b, want %h", tag, fidx,
                     qd[first+fidx], ql[first+fidx], e[fidx]);
        chk({tag, "_bad_words"}, 32'(nmis), 32'd0);
        if (got >= n) chk({tag, "_checksum"}, 32'(qd[first+n-1]), 32'(sum));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wq_t saved;
        int  nmis, n4, bad;
        bit  vb;

        RSTN = 1'b0; START = 1'b0; WR_ACTIVE = 1'b0; TREADY = 1'b0;
        START4 = 1'b0; TREADY4 = 1'b1; WR4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {26'd0, RENBL, TVALID, TLAST, BUSY, DONE, ERR}, 32'd0);
        chk("reset_tdata", 32'(TDATA), 32'd0);
        chk("reset_ctrl4", {25'd0, RENBL4, TVALID4, TLAST4, BUSY4, DONE4, ERR4, |TDATA4}, 32'd0);
        RSTN = 1'b1;
        tick();

        // 1: full-rate frame
        ready_pct = 100;
        start_main();
        wait_done("t1", 4000);
        chk("t1_latency", 32'(d_cyc - s_cyc), 32'(2 + 5 * D0 + 1 + 1));
        check_frame("t1", D0, a0, f0, q_d, q_l);
        chk("t1_renbl", 32'(ren_cnt - ren0), 32'(D0));
        chk("t1_addr_back", 32'(baddr), 32'(a0));
        for (int k = 0; k < 2 + 4 * D0 + 1; k++) saved.push_back(q_d[f0+k]);
        tick();

        // 2: random back-pressure
        ready_pct = 50;
        begin
            int st0;
            st0 = stall_cnt;
            start_main();
            wait_done("t2", 15000);
            check_frame("t2", D0, a0, f0, q_d, q_l);
            chk("t2_renbl", 32'(ren_cnt - ren0), 32'(D0));
            chk("t2_stalls_seen", 32'(stall_cnt > st0), 32'd1);
            chk("t2_stall_stable", 32'(stall_viol), 32'd0);
        end
        ready_pct = 100;
        tick();

        // 3: two back-to-back frames; second equals the first frame of test 1
        start_main();
        wait_done("t3a", 4000);
        check_frame("t3a", D0, a0, f0, q_d, q_l);
        tick();
        start_main();
        wait_done("t3b", 4000);
        nmis = 0;
        for (int k = 0; k < saved.size() && f0 + k < q_d.size(); k++)
            if (q_d[f0+k] !== saved[k]) nmis++;
        chk("t3b_len", 32'(q_d.size() - f0), 32'(saved.size()));
        chk("t3b_vs_first", 32'(nmis), 32'd0);
        tick();

        // 4: write interlock
        WR_ACTIVE = 1'b1;
        ren0  = ren_cnt;
        START = 1'b1;
        tick();
        START = 1'b0;
        vb = 1'b0;
        repeat (5) begin
            tick();
            vb = vb | TVALID | BUSY;
        end
        WR_ACTIVE = 1'b0;
        chk("t4_start_blocked", 32'(vb), 32'd0);
        chk("t4_no_renbl", 32'(ren_cnt - ren0), 32'd0);
        start_main();
        repeat (40) tick();
        WR_ACTIVE = 1'b1;
        tick();
        WR_ACTIVE = 1'b0;
        tick();
        chk("t4_err_set", 32'(ERR), 32'd1);
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done("t4", 4000);
        chk("t4_err_at_done", 32'(ERR), 32'd1);
        check_frame("t4", D0, a0, f0, q_d, q_l);
        tick();
        start_main();
        chk("t4_err_cleared", 32'(ERR), 32'd0);
        wait_done("t4b", 4000);
        check_frame("t4b", D0, a0, f0, q_d, q_l);
        tick();

        // 5: reset mid-frame, then a clean frame from wherever the buffer stands
        start_main();
        for (int n = 0; n < 3000; n++) begin
            if (ren_cnt - ren0 >= 100) break;
            tick();
        end
        chk("t5_reached_100", 32'(ren_cnt - ren0 >= 100), 32'd1);
        RSTN = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_reset_ctrl", {26'd0, RENBL, TVALID, TLAST, BUSY, DONE, ERR}, 32'd0);
        chk("t5_reset_tdata", 32'(TDATA), 32'd0);
        ren0 = ren_cnt;
        @(posedge clk);
        #1;
        chk("t5_reset_no_renbl", 32'(ren_cnt - ren0), 32'd0);
        RSTN = 1'b1;
        tick();
        start_main();
        wait_done("t5", 4000);
        check_frame("t5", D0, a0, f0, q_d, q_l);
        chk("t5_renbl", 32'(ren_cnt - ren0), 32'(D0));
        tick();

        // 6: DEPTH=4 build, checksum wraps
        begin
            int f4, r4, sa4;
            bit ok4;
            f4  = q4_d.size();
            r4  = ren4;
            sa4 = baddr4;
            START4 = 1'b1;
            tick();
            START4 = 1'b0;
            ok4 = 1'b0;
            for (int n = 0; n < 200; n++) begin
                if (DONE4) begin
                    ok4 = 1'b1;
                    break;
                end
                tick();
            end
            chk("t6_done_seen", 32'(ok4), 32'd1);
            n4 = q4_d.size() - f4;
            chk("t6_words", 32'(n4), 32'(2 + 4 * D1 + 1));
            check_frame("t6", D1, sa4, f4, q4_d, q4_l);
            chk("t6_renbl", 32'(ren4 - r4), 32'(D1));
        end

        // Global protocol monitors
        bad = dbl_cnt;
        chk("renbl_back_to_back", 32'(bad), 32'd0);
        chk("renbl_with_tvalid", 32'(overlap), 32'd0);
        chk("stall_stable_all", 32'(stall_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
